// File: rtl/rock_motor_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rock_motor_driver                                         |
// | Brief    : Cradle motor drive: PWM duty from A, direction reversing  |
// |            every half-swing of length set by F, braked stop on AF0.  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module rock_motor_driver #(
  parameter int TICK_DIV    = 50000,
  parameter int HALF_BASE   = 40,
  parameter int HALF_STEP   = 2,
  parameter int BRAKE_TICKS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] A,
  input  logic [3:0] F,
  input  logic       AF0,
  output logic       pwm,
  output logic       dir,
  output logic       brake,
  output logic       busy,
  output logic       half_done
);

  localparam int              c_PW    = $clog2(TICK_DIV);
  localparam logic [c_PW-1:0] c_PMAX  = c_PW'(TICK_DIV - 1);
  localparam logic [c_PW-1:0] c_PONE  = c_PW'(1);
  localparam logic [7:0]      c_BASE  = 8'(HALF_BASE);
  localparam logic [7:0]      c_STEP  = 8'(HALF_STEP);
  localparam logic [7:0]      c_BMAX  = 8'(BRAKE_TICKS - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_POS   = 2'd1;
  localparam logic [1:0] c_NEG   = 2'd2;
  localparam logic [1:0] c_BRAKE = 2'd3;

  logic [1:0]      r_state;
  logic [c_PW-1:0] r_presc;
  logic [3:0]      r_pwm_cnt;
  logic [3:0]      r_a_lat;
  logic [3:0]      r_f_lat;
  logic [7:0]      r_half_cnt;
  logic [7:0]      r_brake_cnt;
  logic            r_pwm;
  logic            r_dir;
  logic            r_brake;
  logic            r_busy;
  logic            r_half_done;

  logic [1:0] w_state_nxt;
  logic       w_latch;
  logic       w_tick;
  logic       w_swing;
  logic       w_half_end;
  logic       w_brake_end;
  logic [7:0] w_half_len;
  logic       w_pwm_nxt;
  logic       w_dir_nxt;
  logic       w_brake_nxt;
  logic       w_busy_nxt;

  assign w_tick      = (r_presc == c_PMAX);
  assign w_swing     = (r_state == c_POS) || (r_state == c_NEG);
  assign w_half_len  = c_BASE - c_STEP * {4'd0, r_f_lat};
  assign w_half_end  = w_swing && w_tick && (r_half_cnt == w_half_len - 8'd1);
  assign w_brake_end = (r_state == c_BRAKE) && w_tick && (r_brake_cnt == c_BMAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= c_IDLE;
      r_pwm       <= 1'b0;
      r_dir       <= 1'b0;
      r_brake     <= 1'b0;
      r_busy      <= 1'b0;
      r_half_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pwm       <= w_pwm_nxt;
      r_dir       <= w_dir_nxt;
      r_brake     <= w_brake_nxt;
      r_busy      <= w_busy_nxt;
      r_half_done <= w_half_end;
    end
  end

  // Stop conditions are only looked at on the reversal tick.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (enable && !AF0) begin
          w_state_nxt = c_POS;
          w_latch     = 1'b1;
        end
      end
      c_POS, c_NEG: begin
        if (w_half_end) begin
          if (AF0 || !enable) begin
            w_state_nxt = c_BRAKE;
          end else begin
            w_state_nxt = (r_state == c_POS) ? c_NEG : c_POS;
            w_latch     = 1'b1;
          end
        end
      end
      c_BRAKE: begin
        if (w_brake_end) w_state_nxt = c_IDLE;
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    w_busy_nxt  = (w_state_nxt != c_IDLE);
    w_brake_nxt = (w_state_nxt == c_BRAKE);
    w_dir_nxt   = 1'b0;
    case (w_state_nxt)
      c_POS:   w_dir_nxt = 1'b1;
      c_NEG:   w_dir_nxt = 1'b0;
      c_BRAKE: w_dir_nxt = r_dir;
      default: w_dir_nxt = 1'b0;
    endcase
    // Gated by the next state too, so pwm is already low in the first brake cycle.
    w_pwm_nxt = w_swing && ((w_state_nxt == c_POS) || (w_state_nxt == c_NEG)) &&
                (r_pwm_cnt < r_a_lat);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc     <= '0;
      r_pwm_cnt   <= 4'd0;
      r_a_lat     <= 4'd0;
      r_f_lat     <= 4'd0;
      r_half_cnt  <= 8'd0;
      r_brake_cnt <= 8'd0;
    end else begin
      r_presc   <= w_tick ? '0 : r_presc + c_PONE;
      r_pwm_cnt <= r_pwm_cnt + 4'd1;
      if (w_latch) begin
        r_a_lat <= A;
        r_f_lat <= F;
      end
      if (r_state == c_IDLE) begin
        r_half_cnt <= 8'd0;
      end else if (w_swing && w_tick) begin
        r_half_cnt <= w_half_end ? 8'd0 : r_half_cnt + 8'd1;
      end
      if ((r_state == c_BRAKE) && w_tick) begin
        r_brake_cnt <= w_brake_end ? 8'd0 : r_brake_cnt + 8'd1;
      end
    end
  end

  assign pwm       = r_pwm;
  assign dir       = r_dir;
  assign brake     = r_brake;
  assign busy      = r_busy;
  assign half_done = r_half_done;

endmodule
`default_nettype wire

// File: tb/tb_rock_motor_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_rock_motor_driver                                      |
// | Brief    : Scoreboard bench for rock_motor_driver (4/20/1/3 params). |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_rock_motor_driver;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       enable = 1'b0;
  logic       AF0    = 1'b0;
  logic [3:0] A      = 4'd0;
  logic [3:0] F      = 4'd0;
  logic       pwm, dir, brake, busy, half_done;

  int checks   = 0;
  int failures = 0;

  // kind 0: half_done event (len = clks since previous reversal, 0 = unchecked;
  //         tot = pwm highs over the whole half, -1 = unchecked)
  // kind 1: return to idle (len = brake clks, tot = pwm highs while braking)
  typedef struct {
    int kind;
    int dir;
    int brk;
    int win;
    int len;
    int tot;
  } ev_t;
  ev_t q[$];

  rock_motor_driver #(
    .TICK_DIV   (4),
    .HALF_BASE  (20),
    .HALF_STEP  (1),
    .BRAKE_TICKS(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .A        (A),
    .F        (F),
    .AF0      (AF0),
    .pwm      (pwm),
    .dir      (dir),
    .brake    (brake),
    .busy     (busy),
    .half_done(half_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic push_half(input int d, input int b, input int w, input int len, input int tot);
    ev_t e;
    e.kind = 0; e.dir = d; e.brk = b; e.win = w; e.len = len; e.tot = tot;
    q.push_back(e);
  endtask

  task automatic push_idle();
    ev_t e;
    e.kind = 1; e.dir = 0; e.brk = 0; e.win = 0; e.len = 12; e.tot = 0;
    q.push_back(e);
  endtask

  // Monitor: pwm history, reversal spacing and brake length, checked on each event.
  logic [15:0] hist      = '0;
  int          gap       = 0;
  int          tot       = 0;
  int          blen      = 0;
  int          bpwm      = 0;
  bit          first     = 1'b1;
  bit          prev_busy = 1'b0;
  ev_t         mon_e;

  always @(negedge clk) begin
    if (reset) begin
      hist = '0; gap = 0; tot = 0; blen = 0; bpwm = 0; first = 1'b1; prev_busy = 1'b0;
    end else begin
      gap++;
      if (half_done) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_half: got a half_done pulse, required none");
        end else begin
          mon_e = q.pop_front();
          check("event_kind_half", 0, mon_e.kind);
          check("half_dir", int'(dir), mon_e.dir);
          check("half_brake", int'(brake), mon_e.brk);
          check("pwm_window16", $countones(hist), mon_e.win);
          if (!first && mon_e.len > 0) check("half_len_clks", gap, mon_e.len);
          if (mon_e.tot >= 0) check("pwm_total_half", tot, mon_e.tot);
        end
        first = 1'b0; gap = 0; tot = 0;
      end
      hist = {hist[14:0], pwm};
      tot += int'(pwm);
      if (brake) begin
        blen++;
        bpwm += int'(pwm);
      end
      if (prev_busy && !busy) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_idle: got busy fall, required none");
        end else begin
          mon_e = q.pop_front();
          check("event_kind_idle", 1, mon_e.kind);
          check("brake_len_clks", blen, mon_e.len);
          check("pwm_during_brake", bpwm, mon_e.tot);
        end
        blen = 0; bpwm = 0; first = 1'b1; tot = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic wait_half();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (half_done !== 1'b1 && n < 400);
    if (half_done !== 1'b1) begin
      checks++; failures++;
      $display("FAIL wait_half: no half_done within %0d cycles, required one", n);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b0 && n < 200);
    if (busy !== 1'b0) begin
      checks++; failures++;
      $display("FAIL wait_idle: busy still %b after %0d cycles, required 0", busy, n);
    end
  endtask

  // Inputs were driven just after an edge; the next edge starts the swing.
  task automatic check_start();
    @(posedge clk);
    @(negedge clk);
    check("start_busy_dir", int'({busy, dir}), 3);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", int'({pwm, dir, brake, busy, half_done}), 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_outputs", int'({pwm, dir, brake, busy, half_done}), 0);

    // Basic swing: half_len 15 ticks = 60 clks, duty 8/16.
    A = 4'd8; F = 4'd5; enable = 1'b1;
    push_half(0, 0, 8, 0, -1);
    push_half(1, 0, 8, 60, -1);
    push_half(0, 0, 8, 60, -1);
    check_start();
    repeat (3) wait_half();

    // Mid-swing update takes effect only at the next reversal.
    repeat (20) @(posedge clk);
    #1; A = 4'd15; F = 4'd15;
    push_half(1, 0, 8, 60, -1);
    push_half(0, 0, 15, 20, -1);
    push_half(1, 0, 15, 20, -1);
    repeat (3) wait_half();

    // Stop via AF0: half completes, then 12-clk brake with dir held.
    repeat (5) @(posedge clk);
    #1; A = 4'd0; F = 4'd0; AF0 = 1'b1;
    push_half(1, 1, 15, 20, -1);
    push_idle();
    wait_half();
    wait_idle();
    repeat (20) @(posedge clk);
    #1;
    check("af0_holds_idle", int'({busy, dir, pwm, brake}), 0);

    // A = 0, F = 0: 80-clk halves, pwm never high; then stop via enable.
    AF0 = 1'b0;
    push_half(0, 0, 0, 0, 0);
    push_half(1, 0, 0, 80, 0);
    check_start();
    repeat (2) wait_half();
    repeat (10) @(posedge clk);
    #1; enable = 1'b0;
    push_half(1, 1, 0, 80, 0);
    push_idle();
    wait_half();
    wait_idle();

    // Asynchronous reset mid-swing, then restart from IDLE.
    @(posedge clk);
    #1; A = 4'd8; F = 4'd5; enable = 1'b1;
    push_half(0, 0, 8, 0, -1);
    check_start();
    wait_half();
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1 check("async_reset_outputs", int'({pwm, dir, brake, busy, half_done}), 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_start();
    push_half(0, 0, 8, 0, -1);
    wait_half();
    repeat (5) @(posedge clk);
    #1; enable = 1'b0;
    push_half(0, 1, 8, 60, -1);
    push_idle();
    wait_half();
    wait_idle();

    repeat (3) @(posedge clk);
    check("scoreboard_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
